gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised, memory-mapped general-purpose I/O bank for the CPU peripheral bus. It provides `NPORTS` independent ports of `WIDTH` pins each, with per-pin direction control, two-flop input synchronisation, and rising/falling edge detection. Edge events latch into write-1-to-clear pending registers, and those registers drive a single interrupt line. It sits beside the existing peripheral decoder on the same `CS`/`adresse`/`write`/`read` bus and replaces fixed 8/11-bit GPI/GPO registers with a scalable bank.

## Interface
- `NPORTS`, default 4: number of ports, 1..16.
- `WIDTH`, default 8: pins per port, 1..16.
- `clk` in 1: CPU clock. Every flop in the block is clocked by this signal.
- `rst` in 1: asynchronous, active-high reset.
- `CS` in 1: bank select from the address decoder.
- `adresse` in 14: word address, local to the bank.
- `write` in 1: write strobe, qualified by `CS`.
- `read` in 1: read strobe. No register has a read side effect.
- `DATAout` in 16: write data from the CPU.
- `DATAin` out 16: read data to the CPU, combinational.
- `pad_in` in NPORTS*WIDTH: asynchronous pin inputs. Port p occupies bits [p*WIDTH +: WIDTH].
- `pad_out` out NPORTS*WIDTH: pin output values.
- `pad_oe` out NPORTS*WIDTH: output enables. 1 means the pin drives.
- `irq` out 1: OR of all pending bits.

## Operation
- Register map: stride of 8 words per port, base address = p*8.
  - +0 `IN`, read-only: synchronised pin levels.
  - +1 `OUT`, read/write.
  - +2 `DIR`, read/write. A 1 bit makes that pin an output.
  - +3 `RISE_EN`, read/write.
  - +4 `FALL_EN`, read/write.
  - +5 `PEND`, write-1-to-clear.
  - +6 `OUT_SET`, write-only. `OUT |= data`.
  - +7 `OUT_CLR`, write-only. `OUT &= ~data`.
- Global register `SUMMARY` at address NPORTS*8, read-only. Bit p = |PEND[p].
- Reads return `{zero-extension, reg[WIDTH-1:0]}`.
- Reads of write-only registers, unmapped addresses, or any access with `CS`=0 return 16'h0000.
- Writes use only `DATAout[WIDTH-1:0]`. Writes to read-only or unmapped addresses are ignored.
- `pad_out` = OUT, `pad_oe` = DIR. `IN` reflects the pad level regardless of DIR, so loopback is readable.
- Edge detect per pin: `s1 <= pad`, `s2 <= s1`, `s3 <= s2`.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- Pending update per bit: `PEND <= (PEND & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)`.
  - `clr` is the write data when `PEND` is written, otherwise 0.
  - If an edge and a clear land on the same bit in the same cycle, the set wins and no event is lost.
- Enabling `RISE_EN`/`FALL_EN` does not retro-latch edges that occurred earlier. Disabling it does not clear existing PEND bits.
- Reset values:
  - OUT, DIR, RISE_EN, FALL_EN, PEND, s1, s2, s3 = 0.
  - Consequently `pad_out` = 0, `pad_oe` = 0 (all pins inputs), `irq` = 0.
  - An input held at 1 through reset therefore produces one rising event after reset, if RISE_EN is already set by then.
- A reset asserted mid-operation clears everything immediately (asynchronous). No partial state survives.

## Timing
- Register write: takes effect on the `clk` edge where `CS` & `write` are both 1. `pad_out`/`pad_oe` change right after that edge.
- Pad to `IN`: a pad change settled before edge k is readable after edge k+1.
- Pad to `PEND`/`irq`: the pending bit sets at edge k+2; `irq` rises after edge k+2.
- A glitch shorter than one clock may be missed. That is accepted.
- `PEND` clear: the bit drops at the write edge, and `irq` falls in the same cycle if no other bit is pending.
- `SUMMARY` and `irq` are combinational from the PEND flops. There is no additional latency.
- The bus is single-cycle. There are no wait states and no ready handshake.

## Structure
- Package `gpio_bank_pkg`:
  - Offsets `OFS_IN` .. `OFS_OUT_CLR` (0..7).
  - `PORT_STRIDE` = 8.
  - A function computing the `SUMMARY` address from NPORTS.
- Sub-module `gpio_port` holds one port: the registers, synchroniser, edge detect, pending logic, and local read mux for a 3-bit offset. `gpio_bank` generates NPORTS instances, decodes the port index, muxes read data, and ORs the irq outputs.

## Test plan
- Reset, then read every register → all 0. `pad_oe` = 0, `irq` = 0.
- Write `DIR`[1] = 8'hFF and `OUT`[1] = 8'hA5, then write `OUT_SET` 8'h0A and `OUT_CLR` 8'h05 → `OUT`[1] = 8'hAA and `pad_out`[15:8] = 8'hAA. With `pad_in` looped back, `IN`[1] = 8'hAA two cycles later.
- `RISE_EN`[0] = 8'h01, then drive pad bit 0 0→1 → `PEND`[0] = 8'h01 at edge +2, `irq` = 1, `SUMMARY` = 16'h0001. Write 8'h01 to `PEND`[0] → `irq` = 0 the next cycle.
- `FALL_EN`[3] = 8'h80, then drive pad bit 31 1→0 while `RISE_EN` = 0 → `PEND`[3] = 8'h80. A 0→1 transition on the same pin sets nothing.
- Time a clear write of `PEND`[2] bit 4 so it lands on the same edge that detects a new rise on that bit → bit stays 1 and `irq` stays 1.
- Assert `rst` mid-way through a pending interrupt with OUT = 8'hFF → `irq`, `pad_out`, `pad_oe` go to 0 immediately, without waiting for a clock edge. Reads to address 14'h3FFF return 16'h0000.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Shared register offsets, address stride and SUMMARY address helper for the gpio_bank
// register map.
package gpio_bank_pkg;

  localparam int unsigned PORT_STRIDE = 8;

  typedef enum logic [2:0] {
    OFS_IN      = 3'd0,
    OFS_OUT     = 3'd1,
    OFS_DIR     = 3'd2,
    OFS_RISE_EN = 3'd3,
    OFS_FALL_EN = 3'd4,
    OFS_PEND    = 3'd5,
    OFS_OUT_SET = 3'd6,
    OFS_OUT_CLR = 3'd7
  } gpio_ofs_e;

  function automatic logic [13:0] summary_addr(input int unsigned nports);
    return 14'(nports * PORT_STRIDE);
  endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: control registers, pad synchroniser, edge detection, W1C pending bits
// and the local read mux.
module gpio_port
  import gpio_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  gpio_ofs_e        ofs_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_out_o,
  output logic [WIDTH-1:0] pad_oe_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             pend_any_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (we_i) begin
      unique case (ofs_i)
        OFS_OUT:     out_d     = wdata_i;
        OFS_DIR:     dir_d     = wdata_i;
        OFS_RISE_EN: rise_en_d = wdata_i;
        OFS_FALL_EN: fall_en_d = wdata_i;
        OFS_PEND:    clr       = wdata_i;
        OFS_OUT_SET: out_d     = out_q | wdata_i;
        OFS_OUT_CLR: out_d     = out_q & ~wdata_i;
        default:     ;
      endcase
    end
    // Set terms are ORed after the clear so a coincident edge is never lost.
    pend_d = (pend_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      s1_q      <= pad_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (ofs_i)
      OFS_IN:      rdata_o = s2_q;
      OFS_OUT:     rdata_o = out_q;
      OFS_DIR:     rdata_o = dir_q;
      OFS_RISE_EN: rdata_o = rise_en_q;
      OFS_FALL_EN: rdata_o = fall_en_q;
      OFS_PEND:    rdata_o = pend_q;
      default:     rdata_o = '0;
    endcase
  end

  assign pad_out_o  = out_q;
  assign pad_oe_o   = dir_q;
  assign pend_any_o = |pend_q;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped bank of NPORTS GPIO ports on the peripheral bus, with a SUMMARY register
// and a single interrupt line.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CS,
  input  logic [13:0]             adresse,
  input  logic                    write,
  input  logic                    read,
  input  logic [15:0]             DATAout,
  output logic [15:0]             DATAin,
  input  logic [NPORTS*WIDTH-1:0] pad_in,
  output logic [NPORTS*WIDTH-1:0] pad_out,
  output logic [NPORTS*WIDTH-1:0] pad_oe,
  output logic                    irq
);

  logic [10:0]      port_sel;
  gpio_ofs_e        ofs;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] port_rdata [NPORTS];
  logic [NPORTS-1:0] pend_any;

  // Reads have no side effects and only the low WIDTH data bits are stored.
  logic unused_bus;
  assign unused_bus = read ^ (^DATAout);

  assign port_sel = adresse[13:3];
  assign ofs      = gpio_ofs_e'(adresse[2:0]);
  assign wdata    = DATAout[WIDTH-1:0];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_port #(
      .WIDTH(WIDTH)
    ) u_port (
      .clk_i     (clk),
      .rst_i     (rst),
      .we_i      (CS & write & (port_sel == 11'(p))),
      .ofs_i     (ofs),
      .wdata_i   (wdata),
      .pad_i     (pad_in[p*WIDTH +: WIDTH]),
      .pad_out_o (pad_out[p*WIDTH +: WIDTH]),
      .pad_oe_o  (pad_oe[p*WIDTH +: WIDTH]),
      .rdata_o   (port_rdata[p]),
      .pend_any_o(pend_any[p])
    );
  end

  // SUMMARY sits at port index NPORTS, so the port loop below never aliases it.
  always_comb begin
    DATAin = '0;
    if (CS) begin
      if (adresse == summary_addr(NPORTS)) begin
        DATAin = 16'(pend_any);
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (port_sel == 11'(p)) DATAin = 16'(port_rdata[p]);
        end
      end
    end
  end

  assign irq = |pend_any;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (NPORTS=4, WIDTH=8) with pin loopback.
module tb_gpio_bank;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned WIDTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CS = 1'b0;
  logic [13:0] adresse = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] DATAout = '0;
  logic [15:0] DATAin;
  logic [31:0] pad_in, pad_out, pad_oe;
  logic [31:0] pad_drv = '0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Output-enabled pins read back their own driven level.
  assign pad_in = (pad_oe & pad_out) | (~pad_oe & pad_drv);

  gpio_bank #(
    .NPORTS(NPORTS),
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .CS     (CS),
    .adresse(adresse),
    .write  (write),
    .read   (read),
    .DATAout(DATAout),
    .DATAin (DATAin),
    .pad_in (pad_in),
    .pad_out(pad_out),
    .pad_oe (pad_oe),
    .irq    (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    CS = 1'b1; write = 1'b1; adresse = a; DATAout = d;
    @(posedge clk);
    #1;
    CS = 1'b0; write = 1'b0; DATAout = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] a, input logic cs_v,
                        input logic [15:0] exp);
    logic [15:0] d;
    CS = cs_v; read = 1'b1; adresse = a;
    #1;
    d = DATAin;
    CS = 1'b0; read = 1'b0;
    check_eq(tag, {16'h0, d}, {16'h0, exp});
  endtask

  initial begin
    // Reset state
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    for (int a = 0; a <= 32; a++) rd_chk("reset_read", 14'(a), 1'b1, 16'h0000);
    check_eq("reset_pad_oe", pad_oe, 32'h0);
    check_eq("reset_pad_out", pad_out, 32'h0);
    check_eq("reset_irq", {31'h0, irq}, 32'h0);

    // Port 1 output path with OUT_SET/OUT_CLR and loopback into IN
    bus_write(14'd10, 16'h00FF);
    bus_write(14'd9, 16'hFFA5);
    bus_write(14'd14, 16'h000A);
    bus_write(14'd15, 16'h0005);
    rd_chk("out1", 14'd9, 1'b1, 16'h00AA);
    check_eq("pad_out_p1", pad_out, 32'h0000_AA00);
    check_eq("pad_oe_p1", pad_oe, 32'h0000_FF00);
    tick(2);
    rd_chk("in1_loopback", 14'd8, 1'b1, 16'h00AA);
    rd_chk("dir1", 14'd10, 1'b1, 16'h00FF);
    rd_chk("out1_cs0", 14'd9, 1'b0, 16'h0000);
    rd_chk("out_set_wo", 14'd14, 1'b1, 16'h0000);
    rd_chk("pend1_none", 14'd13, 1'b1, 16'h0000);

    // Rising edge on port 0 bit 0
    bus_write(14'd3, 16'h0001);
    @(negedge clk);
    pad_drv[0] = 1'b1;
    tick(2);
    rd_chk("pend0_early", 14'd5, 1'b1, 16'h0000);
    check_eq("irq_early", {31'h0, irq}, 32'h0);
    rd_chk("in0", 14'd0, 1'b1, 16'h0001);
    tick(1);
    rd_chk("pend0_set", 14'd5, 1'b1, 16'h0001);
    check_eq("irq_rise", {31'h0, irq}, 32'h1);
    rd_chk("summary0", 14'd32, 1'b1, 16'h0001);
    bus_write(14'd5, 16'h0001);
    check_eq("irq_cleared", {31'h0, irq}, 32'h0);
    rd_chk("pend0_cleared", 14'd5, 1'b1, 16'h0000);

    // Falling edge on pad 31 (port 3 bit 7); rises must not latch
    @(negedge clk);
    pad_drv[31] = 1'b1;
    tick(3);
    bus_write(14'd28, 16'h0080);
    rd_chk("pend3_no_retro", 14'd29, 1'b1, 16'h0000);
    @(negedge clk);
    pad_drv[31] = 1'b0;
    tick(3);
    rd_chk("pend3_fall", 14'd29, 1'b1, 16'h0080);
    rd_chk("summary3", 14'd32, 1'b1, 16'h0008);
    bus_write(14'd29, 16'h0080);
    @(negedge clk);
    pad_drv[31] = 1'b1;
    tick(3);
    rd_chk("pend3_rise_ignored", 14'd29, 1'b1, 16'h0000);
    check_eq("irq_p3_idle", {31'h0, irq}, 32'h0);

    // Port 2 bit 4: clear write coinciding with a fresh rise
    bus_write(14'd19, 16'h0010);
    @(negedge clk);
    pad_drv[20] = 1'b1;
    tick(3);
    rd_chk("pend2_first", 14'd21, 1'b1, 16'h0010);
    rd_chk("summary2", 14'd32, 1'b1, 16'h0004);
    @(negedge clk);
    pad_drv[20] = 1'b0;
    tick(3);
    @(negedge clk);
    pad_drv[20] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(14'd21, 16'h0010);
    rd_chk("pend2_set_wins", 14'd21, 1'b1, 16'h0010);
    check_eq("irq_set_wins", {31'h0, irq}, 32'h1);

    // Asynchronous reset mid-operation
    bus_write(14'd1, 16'h00FF);
    check_eq("pad_out_pre_rst", pad_out, 32'h0000_AAFF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_pad_out", pad_out, 32'h0);
    check_eq("rst_pad_oe", pad_oe, 32'h0);
    tick(1);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    rd_chk("unmapped", 14'h3FFF, 1'b1, 16'h0000);
    rd_chk("pend2_after_rst", 14'd21, 1'b1, 16'h0000);
    rd_chk("rise2_after_rst", 14'd19, 1'b1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
